// File: rtl/hazard_ctrl_pkg.sv
// Shared types and constants for the pipeline sequencing controller.
package hazard_ctrl_pkg;

   localparam int unsigned STATE_W     = 2;
   localparam int unsigned REG_ADDR_W  = 5;
   localparam int unsigned FLUSH_CNT_W = 4;

   localparam logic [31:0]           NOP_INSTR = 32'h0;
   localparam logic [REG_ADDR_W-1:0] REG_ZERO  = 5'd0;

   typedef enum logic [STATE_W-1:0] {
      ST_FLUSH    = 2'd0,
      ST_RUN      = 2'd1,
      ST_MEM_WAIT = 2'd2
   } state_e;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; clear wins over increment.
module sat_counter #(
   parameter int unsigned W = 16
) (
   input  logic         clk_i,
   input  logic         rst_n_i,
   input  logic         inc_i,
   input  logic         clr_i,
   output logic [W-1:0] cnt_o
);

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         cnt_o <= '0;
      end else if (clr_i) begin
         cnt_o <= '0;
      end else if (inc_i && (cnt_o != {W{1'b1}})) begin
         cnt_o <= cnt_o + W'(1);
      end
   end

endmodule

// File: rtl/hazard_ctrl.sv
// Five-stage pipeline sequencing: post-reset flush, load-use stall,
// branch flush and data-memory wait freeze, plus perf counters.
module hazard_ctrl
   import hazard_ctrl_pkg::*;
#(
   parameter int unsigned FLUSH_CYCLES = 4,
   parameter int unsigned CNT_W        = 16
) (
   input  logic                  clk_i,
   input  logic                  rst_n_i,
   input  logic [REG_ADDR_W-1:0] id_rs_addr_i,
   input  logic [REG_ADDR_W-1:0] id_rt_addr_i,
   input  logic                  id_uses_rt_i,
   input  logic                  ex_mem_read_i,
   input  logic [REG_ADDR_W-1:0] ex_rt_addr_i,
   input  logic                  branch_taken_i,
   input  logic                  mem_access_i,
   input  logic                  mem_ack_i,
   input  logic                  cnt_clr_i,
   output logic                  pc_write_o,
   output logic                  if_id_write_o,
   output logic                  if_id_flush_o,
   output logic                  id_ex_bubble_o,
   output logic                  pipe_freeze_o,
   output logic [STATE_W-1:0]    state_o,
   output logic [CNT_W-1:0]      stall_cnt_o,
   output logic [CNT_W-1:0]      flush_cnt_o
);

   state_e                 state_q, state_d;
   logic [FLUSH_CNT_W-1:0] flush_left_q;
   logic                   load_use;
   logic                   mem_wait;
   logic                   stall_inc;
   logic                   flush_inc;

   // ID instruction needs a register that the load in EX has not yet produced
   assign load_use = ex_mem_read_i && (ex_rt_addr_i != REG_ZERO) &&
                     ((ex_rt_addr_i == id_rs_addr_i) ||
                      (id_uses_rt_i && (ex_rt_addr_i == id_rt_addr_i)));

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         state_q <= ST_FLUSH;
      end else begin
         state_q <= state_d;
      end
   end

   // Flush down-counter is re-armed whenever we are outside FLUSH
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         flush_left_q <= FLUSH_CNT_W'(FLUSH_CYCLES);
      end else if (state_q == ST_FLUSH) begin
         flush_left_q <= flush_left_q - FLUSH_CNT_W'(1);
      end else begin
         flush_left_q <= FLUSH_CNT_W'(FLUSH_CYCLES);
      end
   end

   always_comb begin
      state_d        = state_q;
      pc_write_o     = 1'b0;
      if_id_write_o  = 1'b0;
      if_id_flush_o  = 1'b0;
      id_ex_bubble_o = 1'b0;
      pipe_freeze_o  = 1'b0;
      mem_wait       = 1'b0;
      stall_inc      = 1'b0;
      flush_inc      = 1'b0;

      case (state_q)
         ST_FLUSH: begin
            if_id_flush_o  = 1'b1;
            id_ex_bubble_o = 1'b1;
            if (flush_left_q <= FLUSH_CNT_W'(1)) begin
               state_d = ST_RUN;
            end
         end
         ST_RUN, ST_MEM_WAIT: begin
            // Once waiting, only the ack matters; the access is still in EX/MEM
            mem_wait = (state_q == ST_RUN) ? (mem_access_i && !mem_ack_i) : !mem_ack_i;
            if (mem_wait) begin
               pipe_freeze_o = 1'b1;
               state_d       = ST_MEM_WAIT;
            end else begin
               state_d = ST_RUN;
               if (load_use) begin
                  id_ex_bubble_o = 1'b1;
               end else if (branch_taken_i) begin
                  pc_write_o    = 1'b1;
                  if_id_write_o = 1'b1;
                  if_id_flush_o = 1'b1;
                  flush_inc     = 1'b1;
               end else begin
                  pc_write_o    = 1'b1;
                  if_id_write_o = 1'b1;
               end
            end
            stall_inc = !pc_write_o;
         end
         default: begin
            if_id_flush_o  = 1'b1;
            id_ex_bubble_o = 1'b1;
            state_d        = ST_FLUSH;
         end
      endcase
   end

   assign state_o = state_q;

   sat_counter #(.W(CNT_W)) u_stall_cnt (
      .clk_i   (clk_i),
      .rst_n_i (rst_n_i),
      .inc_i   (stall_inc),
      .clr_i   (cnt_clr_i),
      .cnt_o   (stall_cnt_o)
   );

   sat_counter #(.W(CNT_W)) u_flush_cnt (
      .clk_i   (clk_i),
      .rst_n_i (rst_n_i),
      .inc_i   (flush_inc),
      .clr_i   (cnt_clr_i),
      .cnt_o   (flush_cnt_o)
   );

endmodule
